// File: rtl/lieat_alu_pkg.sv
// Shared op encoding and helpers for the registered EXU ALU.
package lieat_alu_pkg;

  localparam int ALU_OP_W = 12;

  // One-hot bit positions within the op vector
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_XOR  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_SLL  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_SLT  = 8;
  localparam int ALU_SLTU = 9;
  localparam int ALU_LUI  = 10;
  localparam int ALU_EBRK = 11;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/lieat_alu_core.sv
// Combinational ALU datapath: operand select, shared add/compare, bit-reverse shifter, word mode.
// Zero latency, no flow control; the caller registers the result.
module lieat_alu_core
  import lieat_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic                word,
  input  logic                pcsel,
  input  logic                immsel,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  output logic [XLEN-1:0]     result,
  output logic                ebreak
);

  localparam logic [XLEN-1:0] LO32 = XLEN'(64'h0000_0000_ffff_ffff);

  logic            word_mode;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] op1_sh;
  logic [SHW-1:0]  shamt;
  logic            is_sub;
  logic [XLEN:0]   add_a;
  logic [XLEN:0]   add_b;
  logic [XLEN:0]   add_res;
  logic [XLEN-1:0] sh_in;
  logic [XLEN-1:0] sh_out;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] fill_src;
  logic [XLEN-1:0] fill;
  logic            sra_msb;
  logic [XLEN-1:0] res_raw;
  logic [XLEN-1:0] res_word;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  always_comb begin
    word_mode = (XLEN == 64) && word;
    op1       = pcsel  ? pc  : src1;
    op2       = immsel ? imm : src2;
    // Word ops see op1 zero-extended so SRLW shifts in zeros above bit 31
    op1_sh    = word_mode ? (op1 & LO32) : op1;
    shamt     = op2[SHW-1:0];
    if (word_mode) shamt[SHW-1] = 1'b0;

    // One XLEN+1 adder serves ADD/SUB and both compares; bit XLEN is the less-than flag
    is_sub  = op[ALU_SUB] | op[ALU_SLT] | op[ALU_SLTU];
    add_a   = {op[ALU_SLT] & op1[XLEN-1], op1};
    add_b   = {op[ALU_SLT] & op2[XLEN-1], op2};
    if (is_sub) add_b = ~add_b;
    add_res = add_a + add_b + {{XLEN{1'b0}}, is_sub};

    sh_in    = op[ALU_SLL] ? op1_sh : bit_rev(op1_sh);
    sh_out   = sh_in << shamt;
    srl_res  = bit_rev(sh_out);
    sra_msb  = word_mode ? op1[31] : op1[XLEN-1];
    fill_src = word_mode ? LO32 : '1;
    fill     = fill_src & ~(fill_src >> shamt) & {XLEN{sra_msb}};

    res_raw = ({XLEN{op[ALU_ADD] | op[ALU_SUB]}}   & add_res[XLEN-1:0])
            | ({XLEN{op[ALU_SLT] | op[ALU_SLTU]}}  & {{(XLEN-1){1'b0}}, add_res[XLEN]})
            | ({XLEN{op[ALU_XOR]}}                 & (op1 ^ op2))
            | ({XLEN{op[ALU_OR]}}                  & (op1 | op2))
            | ({XLEN{op[ALU_AND]}}                 & (op1 & op2))
            | ({XLEN{op[ALU_SLL]}}                 & sh_out)
            | ({XLEN{op[ALU_SRL]}}                 & srl_res)
            | ({XLEN{op[ALU_SRA]}}                 & (srl_res | fill))
            | ({XLEN{op[ALU_LUI]}}                 & op2);
    ebreak  = op[ALU_EBRK];
  end

  if (XLEN == 64) begin : g_word
    assign res_word = sext32(res_raw[31:0]);
  end else begin : g_noword
    assign res_word = res_raw;
  end

  assign result = word_mode ? res_word : res_raw;

endmodule

// File: rtl/lieat_exu_alu_pipe.sv
// Registered EXU ALU: one output stage, result valid 1 cycle after input fire.
// i_ready = ~o_valid | o_ready; output holds while stalled; flush kills the stage and drops the input.
module lieat_exu_alu_pipe
  import lieat_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic                i_word,
  input  logic                i_pcsel,
  input  logic                i_immsel,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [XLEN-1:0]     i_imm,
  input  logic [XLEN-1:0]     i_src1,
  input  logic [XLEN-1:0]     i_src2,
  input  logic [TAG_W-1:0]    i_tag,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [XLEN-1:0]     o_data,
  output logic [TAG_W-1:0]    o_tag,
  output logic                o_ebreak
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]  core_res;
  logic             core_ebk;
  logic             fire;
  logic             valid_d, valid_q;
  logic [XLEN-1:0]  data_d, data_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             ebk_d, ebk_q;

  lieat_alu_core #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_core (
    .op     (i_op),
    .word   (i_word),
    .pcsel  (i_pcsel),
    .immsel (i_immsel),
    .pc     (i_pc),
    .imm    (i_imm),
    .src1   (i_src1),
    .src2   (i_src2),
    .result (core_res),
    .ebreak (core_ebk)
  );

  always_comb begin
    i_ready = ~valid_q | o_ready;
    fire    = i_valid & i_ready & ~flush;
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    ebk_d   = ebk_q;
    if (fire) begin
      valid_d = 1'b1;
      data_d  = core_res;
      tag_d   = i_tag;
      ebk_d   = core_ebk;
    end else if (valid_q & o_ready) begin
      valid_d = 1'b0;
    end
    // Flush wins over a same-cycle fire or hold
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      ebk_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      ebk_q   <= ebk_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_tag    = tag_q;
  assign o_ebreak = ebk_q;

endmodule

// File: tb/tb_lieat_exu_alu_pipe.sv
// Scoreboard bench for lieat_exu_alu_pipe: a 32-bit and a 64-bit instance share clock and reset.
module tb_lieat_exu_alu_pipe;
  import lieat_alu_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        ebk;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                a_flush, a_i_valid, a_i_ready, a_i_word, a_i_pcsel, a_i_immsel;
  logic [ALU_OP_W-1:0] a_i_op;
  logic [31:0]         a_i_pc, a_i_imm, a_i_src1, a_i_src2, a_o_data;
  logic [3:0]          a_i_tag, a_o_tag;
  logic                a_o_valid, a_o_ready, a_o_ebreak;

  logic                b_flush, b_i_valid, b_i_ready, b_i_word, b_i_pcsel, b_i_immsel;
  logic [ALU_OP_W-1:0] b_i_op;
  logic [63:0]         b_i_pc, b_i_imm, b_i_src1, b_i_src2, b_o_data;
  logic [3:0]          b_i_tag, b_o_tag;
  logic                b_o_valid, b_o_ready, b_o_ebreak;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_err = 0;

  lieat_exu_alu_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (
    .clock(clk), .reset(rst), .flush(a_flush), .i_valid(a_i_valid), .i_ready(a_i_ready),
    .i_op(a_i_op), .i_word(a_i_word), .i_pcsel(a_i_pcsel), .i_immsel(a_i_immsel),
    .i_pc(a_i_pc), .i_imm(a_i_imm), .i_src1(a_i_src1), .i_src2(a_i_src2), .i_tag(a_i_tag),
    .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data), .o_tag(a_o_tag),
    .o_ebreak(a_o_ebreak)
  );

  lieat_exu_alu_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
    .clock(clk), .reset(rst), .flush(b_flush), .i_valid(b_i_valid), .i_ready(b_i_ready),
    .i_op(b_i_op), .i_word(b_i_word), .i_pcsel(b_i_pcsel), .i_immsel(b_i_immsel),
    .i_pc(b_i_pc), .i_imm(b_i_imm), .i_src1(b_i_src1), .i_src2(b_i_src2), .i_tag(b_i_tag),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_tag(b_o_tag),
    .o_ebreak(b_o_ebreak)
  );

  always @(posedge clk) begin
    if (a_i_valid) assert ($onehot0(a_i_op)) else $error("multi-hot op on 32-bit instance");
    if (b_i_valid) assert ($onehot0(b_i_op)) else $error("multi-hot op on 64-bit instance");
  end

  function automatic logic [ALU_OP_W-1:0] oh(input int idx);
    logic [ALU_OP_W-1:0] v;
    for (int k = 0; k < ALU_OP_W; k++) v[k] = (k == idx);
    return v;
  endfunction

  task automatic drv_a(input int op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] imm, input logic immsel, input logic pcsel,
                       input logic [31:0] pc, input logic [3:0] tag);
    a_i_valid = 1'b1; a_i_op = oh(op); a_i_src1 = s1; a_i_src2 = s2; a_i_imm = imm;
    a_i_immsel = immsel; a_i_pcsel = pcsel; a_i_pc = pc; a_i_tag = tag; a_i_word = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_o_valid, a_o_data, a_o_tag, a_o_ebreak, a_i_ready} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset32: got v=%b d=%h t=%h e=%b r=%b, want v=0 d=0 t=0 e=0 r=1",
               a_o_valid, a_o_data, a_o_tag, a_o_ebreak, a_i_ready);
    end
    n_cmp++;
    if ({b_o_valid, b_o_data, b_o_tag, b_o_ebreak} !== {1'b0, 64'h0, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset64: got v=%b d=%h t=%h e=%b, want all zero",
               b_o_valid, b_o_data, b_o_tag, b_o_ebreak);
    end
    rst = 1'b0;
  endtask

  task automatic test_arith32();
    int          ops[13];
    logic [31:0] s1[13];
    logic [31:0] s2[13];
    logic [31:0] ex[13];
    exp_t        e;
    logic        use_imm;
    ops = '{ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL, ALU_SLL, ALU_ADD, ALU_XOR, ALU_OR,
            ALU_AND, ALU_SLT, ALU_SRA, -1};
    s1  = '{32'h5, 32'h5, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h1, 32'hFFFFFFFF,
            32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'h80000000, 32'h1234};
    s2  = '{32'h7, 32'h7, 32'h1, 32'd31, 32'd31, 32'h0, 32'h1, 32'hFF00, 32'hFF00, 32'hFF00,
            32'h1, 32'h0, 32'h5678};
    ex  = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h0FF0, 32'hFFF0,
            32'hF000, 32'h1, 32'h80000000, 32'h0};
    a_o_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      use_imm = (i == 3) || (i == 4);
      drv_a(ops[i], s1[i], use_imm ? 32'hDEADBEEF : s2[i], s2[i], use_imm, 1'b0, 32'h0, 4'(i));
      e.data = {32'h0, ex[i]}; e.tag = 4'(i); e.ebk = 1'b0;
      q32.push_back(e);
      @(posedge clk); #1;
      a_i_valid = 1'b0;
      @(negedge clk);
      e = q32.pop_front();
      n_cmp++;
      if ({a_o_valid, a_o_data, a_o_tag, a_o_ebreak} !== {1'b1, e.data[31:0], e.tag, e.ebk}) begin
        n_err++;
        $display("FAIL arith32[%0d]: got v=%b d=%h t=%h e=%b, want v=1 d=%h t=%h e=%b", i,
                 a_o_valid, a_o_data, a_o_tag, a_o_ebreak, e.data[31:0], e.tag, e.ebk);
      end
    end
  endtask

  task automatic test_word64();
    int          ops[13];
    logic        wd[13];
    logic [63:0] s1[13];
    logic [63:0] s2[13];
    logic [63:0] ex[13];
    exp_t        e;
    ops = '{ALU_ADD, ALU_SRA, ALU_SRL, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRL, ALU_SRA, ALU_ADD,
            ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SLL};
    wd  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    s1  = '{64'h7FFFFFFF, 64'h80000000, 64'h8000000000000000, 64'hDEAD000000000005, 64'h1,
            64'hFFFFFFFF80000000, 64'h80000000, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
            64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1};
    s2  = '{64'h1, 64'd4, 64'd63, 64'h3, 64'd31, 64'd4, 64'd0, 64'd63, 64'h2, 64'h1, 64'h1,
            64'd63, 64'h21};
    ex  = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFF8000000, 64'h1, 64'h2, 64'hFFFFFFFF80000000,
            64'h0000000008000000, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1,
            64'h0, 64'h8000000000000000, 64'h2};
    b_o_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      b_i_valid = 1'b1; b_i_op = oh(ops[i]); b_i_word = wd[i]; b_i_src1 = s1[i];
      b_i_src2 = s2[i]; b_i_tag = 4'(i);
      e.data = ex[i]; e.tag = 4'(i); e.ebk = 1'b0;
      q64.push_back(e);
      @(posedge clk); #1;
      b_i_valid = 1'b0;
      @(negedge clk);
      e = q64.pop_front();
      n_cmp++;
      if ({b_o_valid, b_o_data, b_o_tag, b_o_ebreak} !== {1'b1, e.data, e.tag, e.ebk}) begin
        n_err++;
        $display("FAIL word64[%0d]: got v=%b d=%h t=%h e=%b, want v=1 d=%h t=%h e=%b", i,
                 b_o_valid, b_o_data, b_o_tag, b_o_ebreak, e.data, e.tag, e.ebk);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    a_o_ready = 1'b0;
    @(posedge clk); #1;
    drv_a(ALU_ADD, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 32'h0, 4'd3);
    e.data = 64'd30; e.tag = 4'd3; e.ebk = 1'b0;
    q32.push_back(e);
    @(posedge clk); #1;
    // Offered while stalled; must not be taken until the consumer is ready
    drv_a(ALU_ADD, 32'd4, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_o_valid, a_i_ready, a_o_data, a_o_tag} !== {1'b1, 1'b0, 32'd30, 4'd3}) begin
        n_err++;
        $display("FAIL stall[%0d]: got v=%b ir=%b d=%h t=%h, want v=1 ir=0 d=1e t=3", c,
                 a_o_valid, a_i_ready, a_o_data, a_o_tag);
      end
      if (c < 2) @(posedge clk);
    end
    for (int k = 4; k <= 7; k++) begin
      @(posedge clk); #1;
      a_o_ready = 1'b1;
      if (k <= 6) begin
        drv_a(ALU_ADD, 32'(k), 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, 4'(k));
        e.data = 64'(k); e.tag = 4'(k); e.ebk = 1'b0;
        q32.push_back(e);
      end else begin
        a_i_valid = 1'b0;
      end
      @(negedge clk);
      e = q32.pop_front();
      n_cmp++;
      if ({a_o_valid, a_o_data, a_o_tag} !== {1'b1, e.data[31:0], e.tag}) begin
        n_err++;
        $display("FAIL stream[%0d]: got v=%b d=%h t=%h, want v=1 d=%h t=%h", k,
                 a_o_valid, a_o_data, a_o_tag, e.data[31:0], e.tag);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got o_valid=%b, want 0", a_o_valid);
    end
  endtask

  task automatic test_flush();
    a_o_ready = 1'b0;
    @(posedge clk); #1;
    drv_a(ALU_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 32'h0, 4'd7);
    @(posedge clk); #1;
    drv_a(ALU_ADD, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 32'h0, 4'd8);
    a_flush = 1'b1; a_o_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_o_valid, a_o_tag, a_o_data} !== {1'b1, 4'd7, 32'd3}) begin
      n_err++;
      $display("FAIL preflush: got v=%b t=%h d=%h, want v=1 t=7 d=3", a_o_valid, a_o_tag, a_o_data);
    end
    @(posedge clk); #1;
    a_flush = 1'b0; a_i_valid = 1'b0;
    q32.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_o_valid, a_o_tag} !== {1'b0, 4'd7}) begin
        n_err++;
        $display("FAIL flush[%0d]: got v=%b t=%h, want v=0 t=7 (input dropped)", c, a_o_valid, a_o_tag);
      end
    end
  endtask

  task automatic test_reset_midstall();
    a_o_ready = 1'b0;
    @(posedge clk); #1;
    drv_a(ALU_ADD, 32'd2, 32'd2, 32'h0, 1'b0, 1'b0, 32'h0, 4'd10);
    @(posedge clk); #1;
    a_i_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_o_valid, a_o_data, a_o_tag} !== {1'b1, 32'd4, 4'd10}) begin
      n_err++;
      $display("FAIL prereset: got v=%b d=%h t=%h, want v=1 d=4 t=a", a_o_valid, a_o_data, a_o_tag);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_o_valid, a_o_data, a_o_tag, a_o_ebreak} !== {1'b0, 32'h0, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got v=%b d=%h t=%h e=%b, want all zero before next edge",
               a_o_valid, a_o_data, a_o_tag, a_o_ebreak);
    end
    @(negedge clk);
    rst = 1'b0; a_o_ready = 1'b1;
  endtask

  task automatic test_ebreak_lui();
    exp_t e;
    a_o_ready = 1'b1;
    @(posedge clk); #1;
    drv_a(ALU_EBRK, 32'h55, 32'h66, 32'h0, 1'b0, 1'b0, 32'h0, 4'd9);
    e.data = 64'h0; e.tag = 4'd9; e.ebk = 1'b1;
    q32.push_back(e);
    @(posedge clk); #1;
    drv_a(ALU_LUI, 32'h77, 32'h88, 32'h12345000, 1'b1, 1'b1, 32'hDEAD0000, 4'd10);
    e.data = 64'h12345000; e.tag = 4'd10; e.ebk = 1'b0;
    q32.push_back(e);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = q32.pop_front();
      n_cmp++;
      if ({a_o_valid, a_o_data, a_o_tag, a_o_ebreak} !== {1'b1, e.data[31:0], e.tag, e.ebk}) begin
        n_err++;
        $display("FAIL ebreak_lui[%0d]: got v=%b d=%h t=%h e=%b, want v=1 d=%h t=%h e=%b", k,
                 a_o_valid, a_o_data, a_o_tag, a_o_ebreak, e.data[31:0], e.tag, e.ebk);
      end
      @(posedge clk); #1;
      a_i_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_i_valid = 1'b0; a_i_op = '0; a_i_word = 1'b0; a_i_pcsel = 1'b0;
    a_i_immsel = 1'b0; a_i_pc = '0; a_i_imm = '0; a_i_src1 = '0; a_i_src2 = '0; a_i_tag = '0;
    a_o_ready = 1'b1;
    b_flush = 1'b0; b_i_valid = 1'b0; b_i_op = '0; b_i_word = 1'b0; b_i_pcsel = 1'b0;
    b_i_immsel = 1'b0; b_i_pc = '0; b_i_imm = '0; b_i_src1 = '0; b_i_src2 = '0; b_i_tag = '0;
    b_o_ready = 1'b1;
    test_reset();
    test_arith32();
    test_word64();
    test_backpressure();
    test_flush();
    test_reset_midstall();
    test_ebreak_lui();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lieat_exu_alu_pipe.md
Name: lieat_exu_alu_pipe

Overview:
- Parametrised, registered successor to the combinational common ALU in the EXU.
- Supports XLEN of 32 or 64, RV64 word ops (ADDW/SUBW/SLLW/SRLW/SRAW) and a tag passthrough.
- Adds a one-deep output stage with valid/ready backpressure and a flush input.
- Sits between issue and the EXU writeback arbiter.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 4, width of the opaque tag carried from input to output.
- SHW, $clog2(XLEN), shift-amount width; derived, never overridden.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill the in-flight result; the input is dropped in the same cycle.
- i_valid  in  1  input operation valid.
- i_ready  out  1  block can accept an input this cycle.
- i_op  in  ALU_OP_W  one-hot op vector, encoded in the package.
- i_word  in  1  word op: 32-bit compute, result sign-extended; ignored when XLEN=32.
- i_pcsel  in  1  op1 = i_pc instead of i_src1.
- i_immsel  in  1  op2 = i_imm instead of i_src2.
- i_pc, i_imm, i_src1, i_src2  in  XLEN  operands.
- i_tag  in  TAG_W  opaque tag.
- o_valid  out  1  result valid.
- o_ready  in  1  consumer accepts the result.
- o_data  out  XLEN  result.
- o_tag  out  TAG_W  tag of the result.
- o_ebreak  out  1  the result came from an EBREAK op.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: o_valid=0, o_data=0, o_tag=0, o_ebreak=0.
- Ops:
  - ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, LUI (result = op2), EBREAK (result 0, o_ebreak=1).
  - i_op all-zero with i_valid=1 is legal and gives o_data=0.
  - i_op with more than one bit set is illegal; the bench asserts it never occurs.
- Handshake and latency:
  - i_ready = ~o_valid | o_ready, combinational from o_valid and o_ready only.
  - Input fire = i_valid & i_ready & ~flush.
  - Latency is exactly 1 cycle from input fire to o_valid=1.
  - With o_ready held high, throughput is one op per cycle.
- Output register: holds data/tag/ebreak stable while o_valid & ~o_ready. o_valid is cleared by (o_valid & o_ready & ~fire) or by flush.
- Flush has priority over everything: next o_valid=0 and any same-cycle input is discarded. o_data is not required to clear.
- Arithmetic:
  - SLT/SLTU use a single XLEN+1-bit subtractor. The top operand bit is the sign bit for SLT and 0 for SLTU; result = {0..., carry-out bit XLEN}.
  - Shift amount is op2[SHW-1:0], or op2[4:0] when in word mode.
  - SRA is built from the reversed-shift-left datapath plus a fill mask from op1's MSB (bit 31 in word mode).
- Word mode (XLEN=64, i_word=1):
  - Legal only with ADD, SUB, SLL, SRL, SRA.
  - Operands are truncated to [31:0] and the result is sign-extended from bit 31.
  - SRLW shifts zero-extended op1[31:0]; SRAW fills with op1[31].
- Boundaries:
  - Shift of 0 returns op1 unchanged.
  - Shift of XLEN-1 is correct.
  - ADD overflow wraps mod 2^XLEN.
  - Back-to-back fire while the output stalls is impossible, because i_ready=0.
  - Reset mid-operation drops the result immediately (async).

Decomposition:
- Package lieat_alu_pkg:
  - ALU_OP_W=12.
  - One-hot index constants ALU_ADD..ALU_EBRK.
  - Helper function for sign-extension from bit 31.
- Sub-module lieat_alu_core: purely combinational XLEN-parametrised datapath (operand muxing, adder/compare, shared bit-reverse shifter, logic ops, word-mode handling).
- The top level adds only the output register and the handshake/flush control.

Test Plan:
- XLEN=32, SUB: src1=5, src2=7, o_ready=1 -> next cycle o_valid=1, o_data=0xFFFFFFFE; SLT same operands -> 1; SLTU src1=0xFFFFFFFF, src2=1 -> 0.
- XLEN=32, SRA: src1=0x80000000, imm=31, immsel=1 -> 0xFFFFFFFF; SRL same -> 0x00000001; SLL src1=1, shamt 0 -> 1.
- XLEN=64, word ops:
  - ADDW src1=0x7FFFFFFF, src2=1 -> 0xFFFFFFFF80000000.
  - SRAW src1=0x00000000_80000000, shamt 4 -> 0xFFFFFFFF_F8000000.
  - SRL 64-bit, src1=0x8000000000000000, shamt 63 -> 1.
- Backpressure: issue ADD tag=3, hold o_ready=0 for 3 cycles -> i_ready=0 and o_data/o_tag stable for 3 cycles; raise o_ready with a new valid input -> one result per cycle, tags in order.
- Flush: o_valid=1 and i_valid=1 with flush=1 -> next cycle o_valid=0 and the input is not captured; reset asserted mid-stall -> o_valid=0 asynchronously, before the next clock edge.
- EBREAK with tag=9, followed by LUI imm=0x12345000 with pcsel=1 -> first o_ebreak=1, o_data=0; then o_ebreak=0, o_data=0x12345000.
